uart_rx: RTL and testbench

Serial receiver that converts the asynchronous UART line from the host into bytes for the message buffer. It samples the pin at mid-bit, frames 8N1 characters and presents each byte on `rxdata` with a one-cycle `rxfinish` strobe. Downstream, the buffer assembles consecutive bytes into (i, j, status) triples. This block is byte-level only and does not interpret content.

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling, one-cycle
// rxfinish/rxerror strobes and a held rxdata byte.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rxdata,
   output logic       rxfinish,
   output logic       rxerror,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT
   } state_t;

   state_t r_state;
   logic          r_sync1;
   logic          r_rx_s;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [7:0]    r_rxdata;
   logic          r_rxfinish;
   logic          r_rxerror;
   logic          r_busy;

   logic w_half;
   logic w_full;

   assign w_half = (r_cnt == C_HALF);
   assign w_full = (r_cnt == C_FULL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_rx_s  <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_rxdata   <= '0;
         r_rxfinish <= 1'b0;
         r_rxerror  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_rxfinish <= 1'b0;
         r_rxerror  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               r_bit <= '0;
               if (!r_rx_s) begin
                  r_state <= S_START;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (w_half) begin
                  r_cnt <= '0;
                  if (!r_rx_s) begin
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_DATA: begin
               if (w_full) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rx_s, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_STOP: begin
               if (w_full) begin
                  r_cnt <= '0;
                  if (r_rx_s) begin
                     r_rxdata   <= r_shift;
                     r_rxfinish <= 1'b1;
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                  end else begin
                     r_rxerror <= 1'b1;
                     r_state   <= S_WAIT;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            // a line held low (break) parks here until it recovers
            S_WAIT: begin
               r_cnt <= '0;
               if (r_rx_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rxdata   = r_rxdata;
   assign rxfinish = r_rxfinish;
   assign rxerror  = r_rxerror;
   assign busy     = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed 8N1 frames against an event-level
// model of expected pulses (kind, byte, cycle of arrival).
module tb_uart_rx;

   localparam int CPB_A = 16;
   localparam int CPB_B = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic fin_a, err_a, busy_a;
   logic fin_b, err_b, busy_b;

   uart_rx #(.CLKS_PER_BIT(CPB_A)) u_a (
      .clk(clk), .rst(rst), .rx(rx_a),
      .rxdata(data_a), .rxfinish(fin_a),
      .rxerror(err_a), .busy(busy_a)
   );

   uart_rx #(.CLKS_PER_BIT(CPB_B)) u_b (
      .clk(clk), .rst(rst), .rx(rx_b),
      .rxdata(data_b), .rxfinish(fin_b),
      .rxerror(err_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         err;
      logic [7:0] data;
      int         t;
   } ev_t;

   ev_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];
   logic [7:0] last_a = 8'h00;
   logic [7:0] last_b = 8'h00;
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   logic pf_a = 0, pe_a = 0, pf_b = 0, pe_b = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (fin_a || err_a) obs_a.push_back('{err_a, data_a, cyc});
         if (fin_b || err_b) obs_b.push_back('{err_b, data_b, cyc});
         if (fin_a) check("excl_a", err_a, 0);
         if (fin_b) check("excl_b", err_b, 0);
         if (fin_a) check("width_fin_a", pf_a, 0);
         if (err_a) check("width_err_a", pe_a, 0);
         if (fin_b) check("width_fin_b", pf_b, 0);
         if (err_b) check("width_err_b", pe_b, 0);
      end
      pf_a = fin_a; pe_a = err_a;
      pf_b = fin_b; pe_b = err_b;
   end

   task automatic line(input int sel, input logic v);
      if (sel != 0) rx_b = v;
      else rx_a = v;
   endtask

   task automatic idle(input int sel, input int n);
      line(sel, 1'b1);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; leaves the line at the stop-bit value.
   task automatic send(input int sel, input logic [7:0] b, input bit stop);
      int cpb;
      int t0;
      logic [9:0] f;
      ev_t e;
      cpb = (sel != 0) ? CPB_B : CPB_A;
      f = {stop, b, 1'b0};
      t0 = cyc;
      e.err = !stop;
      e.t = t0 + 3 + cpb / 2 + 9 * cpb;
      if (sel != 0) begin
         if (stop) last_b = b;
         e.data = last_b;
         exp_b.push_back(e);
      end else begin
         if (stop) last_a = b;
         e.data = last_a;
         exp_a.push_back(e);
      end
      for (int i = 0; i < 10; i++) begin
         line(sel, f[i]);
         repeat (cpb) @(negedge clk);
      end
   endtask

   task automatic compare(input int sel);
      ev_t e[$];
      ev_t o[$];
      int n;
      int d;
      string nm;
      nm = (sel != 0) ? "B" : "A";
      e = (sel != 0) ? exp_b : exp_a;
      o = (sel != 0) ? obs_b : obs_a;
      check($sformatf("count_%s", nm), o.size(), e.size());
      n = (o.size() < e.size()) ? o.size() : e.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("kind_%s[%0d]", nm, i), o[i].err, e[i].err);
         check($sformatf("data_%s[%0d]", nm, i), o[i].data, e[i].data);
         d = o[i].t - e[i].t;
         check($sformatf("time_%s[%0d] at %0d vs %0d", nm, i, o[i].t,
                         e[i].t), (d >= -1 && d <= 1), 1);
      end
   endtask

   initial begin
      int r;
      int len;
      repeat (3) @(negedge clk);
      #1;
      check("rst_data", data_a, 8'h00);
      check("rst_fin", fin_a, 0);
      check("rst_err", err_a, 0);
      check("rst_busy", busy_a, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 1: single frame
      send(0, 8'hA5, 1);
      idle(0, 2 * CPB_A);
      check("t1_data", data_a, 8'hA5);

      // 2: short low glitch
      line(0, 1'b0);
      repeat (4) @(negedge clk);
      check("t2_busy_hi", busy_a, 1);
      idle(0, 20);
      check("t2_busy_lo", busy_a, 0);
      check("t2_data", data_a, 8'hA5);

      // 3: framing error, held-low line, recovery
      send(0, 8'h3C, 0);
      repeat (40) @(negedge clk);
      check("t3_wait_busy", busy_a, 1);
      check("t3_data_kept", data_a, 8'hA5);
      idle(0, 2 * CPB_A);
      check("t3_idle_busy", busy_a, 0);
      send(0, 8'h01, 1);
      idle(0, 2 * CPB_A);
      check("t3_data", data_a, 8'h01);

      // 4: back-to-back triple
      send(0, 8'h00, 1);
      send(0, 8'hFF, 1);
      send(0, 8'h55, 1);
      idle(0, 2 * CPB_A);
      check("t4_data", data_a, 8'h55);

      // 5: reset mid-frame
      begin
         logic [9:0] f;
         f = {1'b1, 8'h81, 1'b0};
         for (int i = 0; i < 5; i++) begin
            line(0, f[i]);
            repeat (CPB_A) @(negedge clk);
         end
         line(0, f[5]);
         repeat (CPB_A / 2) @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check("t5_rst_data", data_a, 8'h00);
      check("t5_rst_busy", busy_a, 0);
      check("t5_rst_fin", fin_a, 0);
      check("t5_rst_err", err_a, 0);
      line(0, 1'b1);
      last_a = 8'h00;
      last_b = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(0, 2 * CPB_A);
      check("t5_idle_busy", busy_a, 0);
      send(0, 8'h7E, 1);
      idle(0, 2 * CPB_A);
      check("t5_data", data_a, 8'h7E);

      // 6: minimum bit period, back-to-back
      send(1, 8'hC3, 1);
      send(1, 8'h3C, 1);
      idle(1, 3 * CPB_B);
      check("t6_data", data_b, 8'h3C);

      // random mixes on both instances
      for (int k = 0; k < 60; k++) begin
         int sel;
         int cpb;
         sel = (k % 3 == 2) ? 1 : 0;
         cpb = (sel != 0) ? CPB_B : CPB_A;
         r = $urandom_range(0, 9);
         if (r == 0 && cpb / 2 > 1) begin
            len = $urandom_range(1, cpb / 2 - 1);
            line(sel, 1'b0);
            repeat (len) @(negedge clk);
            idle(sel, cpb / 2 + 4 + $urandom_range(0, 8));
         end else if (r == 1) begin
            send(sel, 8'($urandom), 0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            idle(sel, cpb + $urandom_range(0, 8));
         end else begin
            send(sel, 8'($urandom), 1);
            idle(sel, $urandom_range(0, 2 * cpb));
         end
      end
      idle(0, 3 * CPB_A);
      idle(1, 3 * CPB_B);
      check("end_data_a", data_a, last_a);
      check("end_data_b", data_b, last_b);
      check("end_busy_a", busy_a, 0);
      check("end_busy_b", busy_b, 0);

      compare(0);
      compare(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
